// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting NUM_REQ byte streams access to a single TX FIFO write port.
// Each grant lasts up to MAX_BURST bytes, ends early on req_last, and is followed by one turnaround cycle.
module uart_tx_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int MAX_BURST = 8,
   parameter  int DATA_W    = 8,
   localparam int ID_W      = $clog2(NUM_REQ),
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                      clk,
   input  logic                      nReset,
   input  logic                      i_enable,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]        i_req_last,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic                      o_out_valid,
   output logic [DATA_W-1:0]         o_out_data,
   input  logic                      i_out_ready,
   output logic [ID_W-1:0]           o_grant_id,
   output logic                      o_busy,
   output logic                      o_burst_trunc
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_GAP
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   w_rr_ptr_next;
   logic [ID_W-1:0]   r_grant_id;
   logic [ID_W-1:0]   w_grant_id_next;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic [CNT_W-1:0]  w_beat_cnt_next;
   logic [CNT_W-1:0]  w_beat_inc;
   logic              r_burst_trunc;
   logic              w_burst_trunc_next;
   logic [DATA_W-1:0] w_data_arr [NUM_REQ];
   logic [ID_W-1:0]   w_pick_id;
   logic              w_sel_valid;
   logic              w_sel_last;
   logic              w_xfer;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign w_data_arr[gi] = i_req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Scan from rr_ptr upward with wrap; iterating farthest-first leaves the nearest valid requester.
   always_comb begin : p_pick
      int idx;
      idx       = 0;
      w_pick_id = r_rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (i_req_valid[ID_W'(idx)]) begin
            w_pick_id = ID_W'(idx);
         end
      end
   end

   assign w_sel_valid = i_req_valid[r_grant_id];
   assign w_sel_last  = i_req_last[r_grant_id];
   assign w_beat_inc  = r_beat_cnt + CNT_W'(1);
   assign w_xfer      = (r_state == S_XFER) && w_sel_valid && i_out_ready;

   always_comb begin : p_next
      w_state_next       = r_state;
      w_rr_ptr_next      = r_rr_ptr;
      w_grant_id_next    = r_grant_id;
      w_beat_cnt_next    = r_beat_cnt;
      w_burst_trunc_next = 1'b0;
      o_req_ready        = '0;
      o_out_valid        = 1'b0;
      o_out_data         = '0;
      case (r_state)
         S_IDLE: begin
            if (i_enable && (|i_req_valid)) begin
               w_grant_id_next = w_pick_id;
               w_beat_cnt_next = '0;
               w_state_next    = S_XFER;
            end
         end
         S_XFER: begin
            o_out_valid             = w_sel_valid;
            o_out_data              = w_sel_valid ? w_data_arr[r_grant_id] : '0;
            o_req_ready[r_grant_id] = i_out_ready;
            if (w_xfer) begin
               w_beat_cnt_next = w_beat_inc;
               // A message end on the final allowed beat is a normal end, not a truncation.
               if (w_sel_last) begin
                  w_state_next = S_GAP;
               end else if (w_beat_inc == MAX_CNT) begin
                  w_state_next       = S_GAP;
                  w_burst_trunc_next = 1'b1;
               end
            end
         end
         S_GAP: begin
            w_rr_ptr_next = (r_grant_id == LAST_ID) ? '0 : r_grant_id + ID_W'(1);
            w_state_next  = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         r_state       <= S_IDLE;
         r_rr_ptr      <= '0;
         r_grant_id    <= '0;
         r_beat_cnt    <= '0;
         r_burst_trunc <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_rr_ptr      <= w_rr_ptr_next;
         r_grant_id    <= w_grant_id_next;
         r_beat_cnt    <= w_beat_cnt_next;
         r_burst_trunc <= w_burst_trunc_next;
      end
   end

   assign o_grant_id    = r_grant_id;
   assign o_busy        = (r_state != S_IDLE);
   assign o_burst_trunc = r_burst_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester source queues feed the DUT and a
// scoreboard of expected (grant, byte) pairs is popped on every accepted byte.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int MAX_BURST = 8;
   localparam int DATA_W    = 8;

   logic                      clk = 1'b0;
   logic                      nReset;
   logic                      enable;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic                      out_ready;
   logic [1:0]                grant_id;
   logic                      busy;
   logic                      burst_trunc;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .MAX_BURST(MAX_BURST),
      .DATA_W   (DATA_W)
   ) dut (
      .clk          (clk),
      .nReset       (nReset),
      .i_enable     (enable),
      .i_req_valid  (req_valid),
      .i_req_data   (req_data),
      .i_req_last   (req_last),
      .o_req_ready  (req_ready),
      .o_out_valid  (out_valid),
      .o_out_data   (out_data),
      .i_out_ready  (out_ready),
      .o_grant_id   (grant_id),
      .o_busy       (busy),
      .o_burst_trunc(burst_trunc)
   );

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [8:0] src_q [NUM_REQ][$];   // {last, data}
   logic [9:0] sb [$];               // {grant_id, data}
   int         xfer_cyc [$];
   int         run_cyc       = 0;
   int         xfer_cnt      = 0;
   int         last_xfer_cyc = -10;
   int         trunc_cnt     = 0;
   int         stall_at      = -1;
   int         stall_left    = 0;
   int         en_off_at     = -1;
   logic [1:0] stall_gid     = 2'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_msg(input int id, input int base, input int n);
      logic [7:0] d;
      logic       lst;
      for (int k = 0; k < n; k++) begin
         d   = 8'(base + k);
         lst = (k == n - 1);
         src_q[id].push_back({lst, d});
      end
   endtask

   task automatic exp_byte(input int id, input int d);
      logic [1:0] gid;
      logic [7:0] dd;
      gid = 2'(id);
      dd  = 8'(d);
      sb.push_back({gid, dd});
   endtask

   task automatic exp_range(input int id, input int base, input int n);
      for (int k = 0; k < n; k++) begin
         exp_byte(id, base + k);
      end
   endtask

   task automatic drive_inputs();
      logic [8:0] h;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_q[i].size() > 0) begin
            h                   = src_q[i][0];
            req_valid[i]        = 1'b1;
            req_last[i]         = h[8];
            req_data[i*8 +: 8]  = h[7:0];
         end else begin
            req_valid[i]        = 1'b0;
            req_last[i]         = 1'b0;
            req_data[i*8 +: 8]  = 8'h00;
         end
      end
      if (stall_left > 0) begin
         out_ready  = 1'b0;
         stall_left = stall_left - 1;
      end else begin
         out_ready = 1'b1;
      end
   endtask

   task automatic sample();
      logic [9:0] e;
      logic [3:0] one;
      check("ready_onehot", req_ready & ~(4'(1) << grant_id), 0);
      if (!out_valid) check("data_idle_zero", out_data, 0);
      if (!out_ready) begin
         check("stall_ready", req_ready, 0);
         if (stall_at >= 0) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_grant_held", grant_id, stall_gid);
         end
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_xfer", out_valid & out_ready, 0);
         end else begin
            e   = sb.pop_front();
            one = 4'(1) << e[9:8];
            check("out_data", out_data, e[7:0]);
            check("grant_id", grant_id, e[9:8]);
            check("req_ready", req_ready, one);
            $display("xfer cyc=%0d grant=%0d data=0x%02h", run_cyc, grant_id, out_data);
         end
         xfer_cnt++;
         last_xfer_cyc = run_cyc;
         xfer_cyc.push_back(run_cyc);
         if (xfer_cnt == stall_at) stall_left = 5;
         if (xfer_cnt == en_off_at) enable = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i] && req_valid[i] && src_q[i].size() > 0) begin
            void'(src_q[i].pop_front());
         end
      end
      if (burst_trunc) begin
         trunc_cnt++;
         check("trunc_timing", run_cyc, last_xfer_cyc + 1);
      end
      run_cyc++;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         drive_inputs();
         #1;
         sample();
      end
   endtask

   task automatic run(input int budget);
      int n;
      n             = 0;
      run_cyc       = 0;
      xfer_cnt      = 0;
      last_xfer_cyc = -10;
      trunc_cnt     = 0;
      xfer_cyc.delete();
      while (sb.size() > 0 && n < budget) begin
         @(negedge clk);
         drive_inputs();
         #1;
         sample();
         n++;
      end
      check("sb_drained", sb.size(), 0);
      stall_at  = -1;
      en_off_at = -1;
   endtask

   initial begin
      nReset    = 1'b0;
      enable    = 1'b1;
      out_ready = 1'b1;
      req_valid = 4'hF;
      req_last  = 4'hF;
      req_data  = 32'hA5A5A5A5;

      // 1: reset with every requester asserting valid
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_burst_trunc", burst_trunc, 0);
      req_valid = 4'h0;
      nReset    = 1'b1;

      // 2: single 3-byte message from requester 2
      push_msg(2, 'hA1, 3);
      exp_range(2, 'hA1, 3);
      run(50);
      check("t2_xfer_count", xfer_cyc.size(), 3);
      for (int k = 0; k < xfer_cyc.size(); k++) check("t2_xfer_cycle", xfer_cyc[k], 1 + k);
      idle_cycles(2);
      check("t2_no_trunc", trunc_cnt, 0);

      // rr_ptr must now point at 3: requester 3 beats requester 0
      push_msg(0, 'hB0, 1);
      push_msg(3, 'hB3, 1);
      exp_byte(3, 'hB3);
      exp_byte(0, 'hB0);
      run(50);
      idle_cycles(2);

      // 3: round-robin from reset, order 0,1,2,3,0 with two dead cycles between grants
      @(negedge clk);
      nReset = 1'b0;
      @(negedge clk);
      nReset = 1'b1;
      push_msg(0, 'h10, 1);
      push_msg(0, 'h14, 1);
      push_msg(1, 'h11, 1);
      push_msg(2, 'h12, 1);
      push_msg(3, 'h13, 1);
      for (int k = 0; k < 4; k++) exp_byte(k, 'h10 + k);
      exp_byte(0, 'h14);
      run(100);
      check("t3_xfer_count", xfer_cyc.size(), 5);
      for (int k = 0; k < xfer_cyc.size(); k++) check("t3_xfer_cycle", xfer_cyc[k], 1 + 3 * k);
      idle_cycles(2);

      // 4: 12-byte message from 1 is cut at MAX_BURST, requester 3 gets in between
      push_msg(1, 'h40, 12);
      push_msg(3, 'h30, 1);
      exp_range(1, 'h40, MAX_BURST);
      exp_byte(3, 'h30);
      exp_range(1, 'h40 + MAX_BURST, 12 - MAX_BURST);
      run(100);
      check("t4_trunc_count", trunc_cnt, 1);
      idle_cycles(2);

      // 4b: last on exactly the MAX_BURST-th byte is not a truncation
      push_msg(2, 'h50, MAX_BURST);
      exp_range(2, 'h50, MAX_BURST);
      run(100);
      idle_cycles(2);
      check("t4b_no_trunc", trunc_cnt, 0);

      // 5: five cycles of backpressure after the second byte
      push_msg(3, 'h60, 6);
      exp_range(3, 'h60, 6);
      stall_at  = 2;
      stall_gid = 2'd3;
      run(100);
      check("t5_xfer_count", xfer_cnt, 6);
      idle_cycles(2);

      // 6a: enable dropped mid-burst; burst finishes, then no new grant
      push_msg(2, 'h70, 5);
      exp_range(2, 'h70, 5);
      en_off_at = 2;
      run(100);
      check("t6_burst_done", xfer_cnt, 5);
      idle_cycles(2);
      push_msg(0, 'h80, 1);
      idle_cycles(6);
      check("t6_hold_busy", busy, 0);
      check("t6_hold_valid", out_valid, 0);
      enable = 1'b1;
      exp_byte(0, 'h80);
      run(50);
      idle_cycles(2);

      // 6b: reset mid-burst aborts it immediately
      push_msg(1, 'h90, 4);
      exp_range(1, 'h90, 2);
      run(50);
      @(negedge clk);
      drive_inputs();
      nReset = 1'b0;
      @(negedge clk);
      nReset = 1'b1;
      src_q[1].delete();
      drive_inputs();
      #1;
      check("t6_rst_out_valid", out_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_grant", grant_id, 0);
      check("t6_rst_ready", req_ready, 0);
      push_msg(1, 'hA1, 1);
      push_msg(0, 'hA0, 1);
      exp_byte(0, 'hA0);
      exp_byte(1, 'hA1);
      run(50);
      idle_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
